// File: rtl/compare_tally_if.sv
// Sample/result bundle between a magnitude comparator and the compare_tally
// statistics stage. The master drives samples and clear; the slave reports tallies.
interface compare_tally_if #(
    parameter int CNT_W = 8
);
    logic             clr;
    logic             in_valid;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [3:0]       run_len;
    logic [1:0]       last_res;
    logic             locked;
    logic             err;

    modport master (
        output clr, in_valid, gt, lt, eq,
        input  gt_cnt, lt_cnt, eq_cnt, run_len, last_res, locked, err
    );

    modport slave (
        input  clr, in_valid, gt, lt, eq,
        output gt_cnt, lt_cnt, eq_cnt, run_len, last_res, locked, err
    );
endinterface

// File: rtl/compare_tally.sv
// Saturating tallies of comparator outcomes, equal-run tracking and a lock flag
// once the run of equal results reaches LOCK_RUN. All outputs are registered.
module compare_tally #(
    parameter int CNT_W    = 8,
    parameter int LOCK_RUN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    compare_tally_if.slave         s
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       RUN_MAX  = 4'd15;
    localparam logic [3:0]       LOCK_LEN = 4'(LOCK_RUN);

    state_t           r_state;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [3:0]       r_run_len;
    logic [1:0]       r_last_res;
    logic             r_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_gt_nxt;
    logic [CNT_W-1:0] w_lt_nxt;
    logic [CNT_W-1:0] w_eq_nxt;
    logic [3:0]       w_run_nxt;
    logic [3:0]       w_run_inc;
    logic [1:0]       w_last_nxt;
    logic             w_err_nxt;
    logic             w_onehot;

    assign w_onehot  = $onehot({s.gt, s.lt, s.eq});
    assign w_run_inc = (r_run_len == RUN_MAX) ? RUN_MAX : r_run_len + 4'd1;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_gt_nxt    = r_gt_cnt;
        w_lt_nxt    = r_lt_cnt;
        w_eq_nxt    = r_eq_cnt;
        w_run_nxt   = r_run_len;
        w_last_nxt  = r_last_res;
        w_err_nxt   = r_err;

        if (s.clr) begin
            // Clear wins over any sample presented in the same cycle.
            w_state_nxt = IDLE;
            w_gt_nxt    = '0;
            w_lt_nxt    = '0;
            w_eq_nxt    = '0;
            w_run_nxt   = '0;
            w_last_nxt  = 2'b00;
            w_err_nxt   = 1'b0;
        end else if (s.in_valid && !w_onehot) begin
            w_err_nxt = 1'b1;
        end else if (s.in_valid) begin
            if (s.eq) begin
                if (r_eq_cnt != '1) w_eq_nxt = r_eq_cnt + CNT_ONE;
                w_run_nxt  = w_run_inc;
                w_last_nxt = 2'b11;
                if (w_run_inc >= LOCK_LEN || r_state == LOCKED) w_state_nxt = LOCKED;
                else                                             w_state_nxt = TRACK;
            end else begin
                if (s.gt) begin
                    if (r_gt_cnt != '1) w_gt_nxt = r_gt_cnt + CNT_ONE;
                    w_last_nxt = 2'b10;
                end else begin
                    if (r_lt_cnt != '1) w_lt_nxt = r_lt_cnt + CNT_ONE;
                    w_last_nxt = 2'b01;
                end
                w_run_nxt   = '0;
                w_state_nxt = TRACK;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gt_cnt   <= '0;
            r_lt_cnt   <= '0;
            r_eq_cnt   <= '0;
            r_run_len  <= '0;
            r_last_res <= 2'b00;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gt_cnt   <= w_gt_nxt;
            r_lt_cnt   <= w_lt_nxt;
            r_eq_cnt   <= w_eq_nxt;
            r_run_len  <= w_run_nxt;
            r_last_res <= w_last_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign s.gt_cnt   = r_gt_cnt;
    assign s.lt_cnt   = r_lt_cnt;
    assign s.eq_cnt   = r_eq_cnt;
    assign s.run_len  = r_run_len;
    assign s.last_res = r_last_res;
    assign s.locked   = (r_state == LOCKED);
    assign s.err      = r_err;
endmodule

// File: tb/tb_compare_tally.sv
// Randomized and directed bench for compare_tally against an arithmetic model
// of tallies, equal-run length, last result, lock and error flags.
module tb_compare_tally;
    localparam int CNT_W    = 4;
    localparam int LOCK_RUN = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    // Reference state, updated from the sample rules at every rising edge.
    int m_gt, m_lt, m_eq, m_run, m_last, m_err;

    compare_tally_if #(.CNT_W(CNT_W)) bus ();

    compare_tally #(.CNT_W(CNT_W), .LOCK_RUN(LOCK_RUN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            m_gt = 0; m_lt = 0; m_eq = 0; m_run = 0; m_last = 0; m_err = 0;
        end else if (bus.in_valid) begin
            if (int'(bus.gt) + int'(bus.lt) + int'(bus.eq) != 1) begin
                m_err = 1;
            end else if (bus.eq) begin
                m_eq   = (m_eq < CNT_MAX) ? m_eq + 1 : CNT_MAX;
                m_run  = (m_run < 15) ? m_run + 1 : 15;
                m_last = 3;
            end else if (bus.gt) begin
                m_gt   = (m_gt < CNT_MAX) ? m_gt + 1 : CNT_MAX;
                m_run  = 0;
                m_last = 2;
            end else begin
                m_lt   = (m_lt < CNT_MAX) ? m_lt + 1 : CNT_MAX;
                m_run  = 0;
                m_last = 1;
            end
        end
    end

    // Lock is held exactly while the current equal run is at least LOCK_RUN long.
    always @(negedge clk) begin
        if (rst_n !== 1'bx && $time > 20) begin
            check("gt_cnt",   int'(bus.gt_cnt),   m_gt);
            check("lt_cnt",   int'(bus.lt_cnt),   m_lt);
            check("eq_cnt",   int'(bus.eq_cnt),   m_eq);
            check("run_len",  int'(bus.run_len),  m_run);
            check("last_res", int'(bus.last_res), m_last);
            check("locked",   int'(bus.locked),   (m_run >= LOCK_RUN) ? 1 : 0);
            check("err",      int'(bus.err),      m_err);
        end
    end

    task automatic step(input logic v, input logic g, input logic l, input logic e);
        bus.in_valid = v; bus.gt = g; bus.lt = l; bus.eq = e;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.gt = 1'b0; bus.lt = 1'b0; bus.eq = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; bus.clr = 1'b0;
        bus.in_valid = 1'b0; bus.gt = 1'b0; bus.lt = 1'b0; bus.eq = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("idle_eq_cnt", int'(bus.eq_cnt), 0);
            check("idle_locked", int'(bus.locked), 0);
            check("idle_err",    int'(bus.err),    0);
        end

        // Lock sequence: gt, eq, eq, eq, lt
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("lock_early", int'(bus.locked), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("lock_run3",   int'(bus.run_len), 3);
        check("lock_locked", int'(bus.locked),  1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("unlock_run",    int'(bus.run_len),  0);
        check("unlock_locked", int'(bus.locked),   0);
        check("unlock_last",   int'(bus.last_res), 1);
        check("unlock_gt",     int'(bus.gt_cnt),   1);
        check("unlock_eq",     int'(bus.eq_cnt),   3);
        check("unlock_lt",     int'(bus.lt_cnt),   1);

        // Malformed samples, then a valid lt
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("bad_err",  int'(bus.err),      1);
        check("bad_gt",   int'(bus.gt_cnt),   1);
        check("bad_eq",   int'(bus.eq_cnt),   3);
        check("bad_last", int'(bus.last_res), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("bad_lt_inc", int'(bus.lt_cnt), 2);
        check("bad_sticky", int'(bus.err),    1);

        // Saturation with 4-bit counters
        pulse_clr();
        check("clr_err", int'(bus.err), 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("sat_eq",     int'(bus.eq_cnt),  15);
        check("sat_run",    int'(bus.run_len), 15);
        check("sat_locked", int'(bus.locked),  1);

        // Clear together with an eq sample while locked
        bus.clr = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        bus.clr = 1'b0;
        check("clrs_eq",     int'(bus.eq_cnt),   0);
        check("clrs_run",    int'(bus.run_len),  0);
        check("clrs_last",   int'(bus.last_res), 0);
        check("clrs_locked", int'(bus.locked),   0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("post_clr_eq",     int'(bus.eq_cnt),  1);
        check("post_clr_run",    int'(bus.run_len), 1);
        check("post_clr_locked", int'(bus.locked),  0);

        // Reset mid-run
        pulse_clr();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_run",    int'(bus.run_len), 1);
        check("rst_locked", int'(bus.locked),  0);
        check("rst_eq",     int'(bus.eq_cnt),  1);

        // Random traffic, biased toward eq runs so lock toggles often
        for (int i = 0; i < 600; i++) begin
            logic [2:0] f;
            int         r;
            r = int'($urandom_range(0, 9));
            case (r)
                0:       f = 3'($urandom_range(0, 7));
                1, 2:    f = 3'b100;
                3, 4:    f = 3'b010;
                default: f = 3'b001;
            endcase
            bus.clr = ($urandom_range(0, 49) == 0);
            rst_n   = ($urandom_range(0, 79) != 0);
            step(($urandom_range(0, 5) != 0), f[2], f[1], f[0]);
            bus.clr = 1'b0;
            rst_n   = 1'b1;
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
